booth_div: RTL and testbench
============================

Name: booth_div

Overview:
- Sequential signed integer divider; the inverse datapath to the team's Booth multiplier.
- Takes a product-width dividend and a multiplier-width divisor. Returns a product-width quotient and a divisor-width remainder.
- Radix-2 restoring iteration on magnitudes: one quotient bit per clock, then a sign-fix cycle.
- Sits beside the multiplier in the arithmetic unit and uses the same load-pulse launch style, plus a busy/done handshake.

Parameters:
- N_WIDTH, 32, dividend and quotient width.
- D_WIDTH, 8, divisor and remainder width; must be ≥ 2 and ≤ N_WIDTH.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- load  in  1  start request; sampled on clk.
- N  in  N_WIDTH  signed dividend, sampled when load is accepted.
- D  in  D_WIDTH  signed divisor, sampled when load is accepted.
- Q  out  N_WIDTH  signed quotient, registered.
- R  out  D_WIDTH  signed remainder, registered.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when Q/R/flags become valid.
- dbz  out  1  divide-by-zero flag, valid with done, held until next done.
- ovf  out  1  overflow flag, valid with done, held until next done.

Behaviour:
- Reset (sync, active-high, overrides load): state=IDLE; Q=0, R=0, busy=0, done=0, dbz=0, ovf=0. A reset mid-operation abandons the operation; no done is produced.
- States: IDLE, DIV, FIX, DONE.
- IDLE/DONE + load=1 → accept the operands:
  - Latch sign_q = N[msb]^D[msb] and sign_r = N[msb].
  - Latch |N| (N_WIDTH unsigned) and |D| (D_WIDTH unsigned; |−2^(D_WIDTH−1)| is representable).
  - Clear the partial remainder (D_WIDTH+1 bits).
  - Load the iteration counter with N_WIDTH.
- Special cases, detected at acceptance; these go to DONE next cycle and skip DIV/FIX:
  - D==0: Q=all ones, R=N[D_WIDTH−1:0], dbz=1, ovf=0.
  - N==−2^(N_WIDTH−1) and D==−1: Q=−2^(N_WIDTH−1), R=0, ovf=1, dbz=0.
  - Otherwise go to DIV; dbz=0, ovf=0.
- DIV, one bit per cycle, MSB first:
  - rem = {rem, dividend msb}; shift the dividend register left.
  - If rem ≥ |D|: rem −= |D| and shift in quotient bit 1; else shift in 0.
  - Decrement the counter; after exactly N_WIDTH DIV cycles go to FIX.
- FIX (1 cycle):
  - Q = sign_q ? −qmag : qmag.
  - R = sign_r ? −rem : rem.
  - Result: truncation toward zero; R carries the sign of N; |R| < |D|.
  - Go to DONE.
- DONE (1 cycle): done=1.
  - With load=1: accept the new operands in that same cycle (back-to-back).
  - Otherwise go to IDLE.
- busy=1 in DIV and FIX, 0 in IDLE and DONE.
- Latency:
  - Normal case: load accepted at edge k → done high during cycle k+N_WIDTH+2, i.e. 34 cycles at default parameters.
  - Special cases: done high in cycle k+1.
- load while busy=1 is ignored, with no effect on the operation in flight.
- Q, R, dbz, ovf change only on entry to DONE and otherwise hold their last values. Special cases drive Q/R/flags on that DONE entry; in the normal flow Q/R are written in FIX, and dbz/ovf are cleared on the entry to DONE.
- N and D may change freely after acceptance.

Test Plan:
- Reset, then load N=100, D=7 → done exactly 34 cycles later; Q=14, R=2, dbz=0, ovf=0; busy high for 33 cycles.
- Sign combinations at default widths:
  - N=−100, D=7 → Q=0xFFFFFFF2 (−14), R=0xFE (−2).
  - N=100, D=−7 → Q=−14, R=2.
  - N=−100, D=−7 → Q=14, R=0xFE.
- Edge operands:
  - N=0x7FFFFFFF, D=−128 → Q=−16777215, R=127.
  - N=−2^31, D=1 → Q=0x80000000, R=0, ovf=0.
  - N=−2^31, D=−1 → done after 1 cycle; Q=0x80000000, R=0, ovf=1.
- N=5, D=0 → done after 1 cycle, Q=0xFFFFFFFF, R=0x05, dbz=1. A following normal op clears dbz at its done.
- Handshake:
  - Pulse load with new operands at cycle 10 of an op → ignored; first result correct.
  - Assert load in the DONE cycle → second op starts, done 34 cycles later.
- Assert rst at cycle 20 of an op → all outputs 0 next cycle, no done pulse. A subsequent load 9/3 → Q=3, R=0.

Source files
------------

// File: rtl/booth_div_if.sv
// booth_div_if: operand/result bundle for the booth_div sequential divider.
//   master : requester side, which drives load, N and D and observes the results
//   slave  : divider side, which drives Q, R, busy, done, dbz and ovf
//   load   start request, sampled on clk
//   N, D   signed dividend (N_WIDTH) and signed divisor (D_WIDTH)
//   Q, R   signed quotient (N_WIDTH) and signed remainder (D_WIDTH), registered
//   busy   operation in flight; done is a one-cycle result strobe
//   dbz    divide-by-zero flag; ovf is the overflow flag (-2^(N_WIDTH-1) / -1)
interface booth_div_if #(
    parameter int N_WIDTH = 32,
    parameter int D_WIDTH = 8
);
    logic               load;
    logic [N_WIDTH-1:0] N;
    logic [D_WIDTH-1:0] D;
    logic [N_WIDTH-1:0] Q;
    logic [D_WIDTH-1:0] R;
    logic               busy;
    logic               done;
    logic               dbz;
    logic               ovf;

    modport master (
        output load, N, D,
        input  Q, R, busy, done, dbz, ovf
    );

    modport slave (
        input  load, N, D,
        output Q, R, busy, done, dbz, ovf
    );
endinterface

// File: rtl/booth_div.sv
// booth_div: sequential signed divider using radix-2 restoring division on
// magnitudes. It produces one quotient bit per clock, then spends one cycle
// fixing the signs. The result truncates toward zero, and R carries the sign of N.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; abandons any operation in flight
//   bus  booth_div_if.slave (load/N/D in; Q/R/busy/done/dbz/ovf out)
// Latency: normal operations raise done N_WIDTH+1 edges after the accepting edge.
// Divide-by-zero and the single overflow case raise done right after acceptance.
module booth_div #(
    parameter int N_WIDTH = 32,
    parameter int D_WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    booth_div_if.slave   bus
);
    localparam int CW = $clog2(N_WIDTH + 1);
    localparam logic [N_WIDTH-1:0] N_MIN = {1'b1, {(N_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t             state;
    logic               sign_q;
    logic               sign_r;
    logic [N_WIDTH-1:0] dvd;      // dividend shifts out the top while quotient bits shift in at the bottom
    logic [D_WIDTH-1:0] d_mag_r;
    logic [D_WIDTH-1:0] rem;      // partial remainder, always < |D| between steps
    logic [CW-1:0]      cnt;

    // Magnitudes of the incoming operands. |-2^(D_WIDTH-1)| fits as an unsigned value.
    logic [N_WIDTH-1:0] n_mag;
    logic [D_WIDTH-1:0] d_mag;
    logic               d_zero;
    logic               ovf_case;

    assign n_mag    = bus.N[N_WIDTH-1] ? (~bus.N + N_WIDTH'(1)) : bus.N;
    assign d_mag    = bus.D[D_WIDTH-1] ? (~bus.D + D_WIDTH'(1)) : bus.D;
    assign d_zero   = (bus.D == '0);
    assign ovf_case = (bus.N == N_MIN) && (&bus.D);

    // Restoring step. The shifted remainder needs D_WIDTH+1 bits for the compare.
    // The difference always fits in D_WIDTH bits, because it is taken only when
    // rem_sh >= |D|, which guarantees rem_sh - |D| < |D|.
    logic [D_WIDTH:0]   rem_sh;
    logic               ge;
    logic [D_WIDTH-1:0] diff;

    assign rem_sh = {rem, dvd[N_WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, d_mag_r});
    assign diff   = rem_sh[D_WIDTH-1:0] - d_mag_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dvd      <= '0;
            d_mag_r  <= '0;
            rem      <= '0;
            cnt      <= '0;
            bus.Q    <= '0;
            bus.R    <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.dbz  <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.load) begin
                        sign_q  <= bus.N[N_WIDTH-1] ^ bus.D[D_WIDTH-1];
                        sign_r  <= bus.N[N_WIDTH-1];
                        dvd     <= n_mag;
                        d_mag_r <= d_mag;
                        rem     <= '0;
                        cnt     <= CW'(N_WIDTH);
                        if (d_zero) begin
                            bus.Q    <= '1;
                            bus.R    <= bus.N[D_WIDTH-1:0];
                            bus.dbz  <= 1'b1;
                            bus.ovf  <= 1'b0;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else if (ovf_case) begin
                            bus.Q    <= N_MIN;
                            bus.R    <= '0;
                            bus.dbz  <= 1'b0;
                            bus.ovf  <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            bus.busy <= 1'b1;
                            state    <= DIV;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                DIV: begin
                    rem <= ge ? diff : rem_sh[D_WIDTH-1:0];
                    dvd <= {dvd[N_WIDTH-2:0], ge};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FIX;
                end
                FIX: begin
                    bus.Q    <= sign_q ? (~dvd + N_WIDTH'(1)) : dvd;
                    bus.R    <= sign_r ? (~rem + D_WIDTH'(1)) : rem;
                    bus.dbz  <= 1'b0;
                    bus.ovf  <= 1'b0;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_div.sv
// tb_booth_div: directed, table-driven bench for booth_div at default widths.
// It also runs hand-written sequences for ignored load, back-to-back launch and
// mid-operation reset.
module tb_booth_div;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_div_if #(.N_WIDTH(32), .D_WIDTH(8)) bus ();
    booth_div #(.N_WIDTH(32), .D_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] n;
        logic [7:0]  d;
        logic [31:0] q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one op and wait for done. lat counts edges from the accepting edge
    // (1) to the edge after which done is seen; -1 means it timed out.
    // When inj matches a cycle, a conflicting load is pulsed during that cycle.
    task automatic run_op(input logic [31:0] n, input logic [7:0] d, input int inj,
                          output int lat, output int busy_cnt);
        bus.N = n; bus.D = d; bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.N = 32'hDEAD_BEEF; bus.D = 8'h00;
        lat = 1; busy_cnt = 0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            if (lat == inj) begin
                bus.load = 1'b1; bus.N = 32'd50; bus.D = 8'd3;
            end else begin
                bus.load = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.load = 1'b0;
        if (!bus.done) lat = -1;
    endtask

    initial begin
        int lat, bc, seen;

        vecs[0]  = '{32'd100,      8'd7,   32'd14,       8'h02, 1'b0, 1'b0, 34};
        vecs[1]  = '{32'hFFFFFF9C, 8'd7,   32'hFFFFFFF2, 8'hFE, 1'b0, 1'b0, 34};
        vecs[2]  = '{32'd100,      8'hF9,  32'hFFFFFFF2, 8'h02, 1'b0, 1'b0, 34};
        vecs[3]  = '{32'hFFFFFF9C, 8'hF9,  32'd14,       8'hFE, 1'b0, 1'b0, 34};
        vecs[4]  = '{32'h7FFFFFFF, 8'h80,  32'hFF000001, 8'h7F, 1'b0, 1'b0, 34};
        vecs[5]  = '{32'h80000000, 8'h01,  32'h80000000, 8'h00, 1'b0, 1'b0, 34};
        vecs[6]  = '{32'h80000000, 8'hFF,  32'h80000000, 8'h00, 1'b0, 1'b1, 1};
        vecs[7]  = '{32'd5,        8'h00,  32'hFFFFFFFF, 8'h05, 1'b1, 1'b0, 1};
        vecs[8]  = '{32'd9,        8'd3,   32'd3,        8'h00, 1'b0, 1'b0, 34};
        vecs[9]  = '{32'd1000,     8'd33,  32'd30,       8'h0A, 1'b0, 1'b0, 34};
        vecs[10] = '{32'd3,        8'd7,   32'd0,        8'h03, 1'b0, 1'b0, 34};
        vecs[11] = '{32'hFFFFFFFF, 8'd2,   32'd0,        8'hFF, 1'b0, 1'b0, 34};

        rst = 1'b1; bus.load = 1'b0; bus.N = '0; bus.D = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.q", bus.Q, 32'd0);
        check("reset.r", {24'd0, bus.R}, 32'd0);
        check("reset.busy", {31'd0, bus.busy}, 32'd0);
        check("reset.done", {31'd0, bus.done}, 32'd0);
        check("reset.dbz", {31'd0, bus.dbz}, 32'd0);
        check("reset.ovf", {31'd0, bus.ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].n, vecs[i].d, 0, lat, bc);
            check($sformatf("v%0d.q", i), bus.Q, vecs[i].q);
            check($sformatf("v%0d.r", i), {24'd0, bus.R}, {24'd0, vecs[i].r});
            check($sformatf("v%0d.dbz", i), {31'd0, bus.dbz}, {31'd0, vecs[i].dbz});
            check($sformatf("v%0d.ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
            check($sformatf("v%0d.lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d.busy_cycles", i), bc, (vecs[i].lat == 34) ? 33 : 0);
            @(posedge clk); #1;
            check($sformatf("v%0d.done_pulse", i), {31'd0, bus.done}, 32'd0);
        end

        // load pulsed mid-operation must be ignored
        run_op(32'd100, 8'd7, 10, lat, bc);
        check("ign.q", bus.Q, 32'd14);
        check("ign.r", {24'd0, bus.R}, 32'd2);
        check("ign.lat", lat, 34);
        @(posedge clk); #1;
        check("ign.after", {31'd0, bus.done | bus.busy}, 32'd0);

        // back-to-back: second load is raised during the DONE cycle of the first
        run_op(32'd100, 8'd7, 0, lat, bc);
        check("b2b0.q", bus.Q, 32'd14);
        run_op(32'hFFFFFF9C, 8'hF9, 0, lat, bc);
        check("b2b1.lat", lat, 34);
        check("b2b1.q", bus.Q, 32'd14);
        check("b2b1.r", {24'd0, bus.R}, 32'h0000_00FE);
        @(posedge clk); #1;

        // reset during an operation: outputs clear, no done is produced
        bus.N = 32'd100; bus.D = 8'd7; bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst.q", bus.Q, 32'd0);
        check("rst.r", {24'd0, bus.R}, 32'd0);
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        check("rst.done", {31'd0, bus.done}, 32'd0);
        check("rst.flags", {30'd0, bus.dbz, bus.ovf}, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen = 1;
        end
        check("rst.no_done", seen, 0);
        run_op(32'd9, 8'd3, 0, lat, bc);
        check("post_rst.q", bus.Q, 32'd3);
        check("post_rst.r", {24'd0, bus.R}, 32'd0);
        check("post_rst.lat", lat, 34);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
